ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter_if.sv | 41 ++++
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports, the RAM wrapper strobes and the status
// outputs of ram_port_arbiter. The arbiter uses the slave view.
interface ram_port_arbiter_if;
  // Requesters raise req with we/addr/wdata stable and hold it until their
  // one-cycle ack; req must be low by the edge that ends the ack cycle.
  logic        p0_req,   p1_req;
  logic        p0_we,    p1_we;
  logic [25:0] p0_addr,  p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_ack,   p1_ack;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_err,   p1_err;

  logic [25:0] ram_address;
  logic [7:0]  ram_data_in;
  logic        ram_write_enable;
  logic        ram_read_request;
  logic        ram_read_ack;
  logic [7:0]  ram_data_out;
  logic        ram_rdy;
  logic        ram_rd_data_pres;

  logic        busy;
  logic [1:0]  grant;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  ram_data_out, ram_rdy, ram_rd_data_pres,
    output p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err,
    output ram_address, ram_data_in, ram_write_enable, ram_read_request, ram_read_ack,
    output busy, grant
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output ram_data_out, ram_rdy, ram_rd_data_pres,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err,
    input  ram_address, ram_data_in, ram_write_enable, ram_read_request, ram_read_ack,
    input  busy, grant
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single byte-wide RAM wrapper.
// Every output is a register loaded from the next state (Moore, glitch-free).
module ram_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_port_arbiter_if.slave    bus,
    output logic [2:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_CMD  = 3'd2,
        RD_WAIT = 3'd3,
        RD_ACK  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q,  last_d;
    logic               to_q,    to_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [25:0]        addr_q,  addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               pick;

    logic [7:0]         rdata0_q, rdata1_q;
    logic [1:0]         ack_q, err_q, grant_q;
    logic               busy_q, wen_q, rreq_q, rack_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pick    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ram_rdy && (bus.p0_req || bus.p1_req)) begin
                    // On a tie the port that did not win last time goes first.
                    pick    = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;
                    owner_d = pick;
                    last_d  = pick;
                    to_d    = 1'b0;
                    addr_d  = pick ? bus.p1_addr  : bus.p0_addr;
                    wdata_d = pick ? bus.p1_wdata : bus.p0_wdata;
                    state_d = (pick ? bus.p1_we : bus.p0_we) ? WR : RD_CMD;
                end
            end
            WR:     state_d = DONE;
            RD_CMD: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                if (bus.ram_rd_data_pres) begin
                    state_d = RD_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d = DONE;
                        to_d    = 1'b1;
                    end
                end
            end
            RD_ACK: state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            to_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            wen_q    <= 1'b0;
            rreq_q   <= 1'b0;
            rack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= (state_d != IDLE);
            grant_q <= (state_d == IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
            wen_q   <= (state_d == WR);
            rreq_q  <= (state_d == RD_CMD);
            rack_q  <= (state_d == RD_ACK);
            ack_q   <= (state_d == DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
            err_q   <= (state_d == DONE && to_d) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
            // Read byte is sampled at the end of the read-ack cycle, so it is
            // visible together with the requester's ack.
            if (state_q == RD_ACK) begin
                if (owner_q) rdata1_q <= bus.ram_data_out;
                else         rdata0_q <= bus.ram_data_out;
            end
        end
    end

    assign bus.p0_ack           = ack_q[0];
    assign bus.p1_ack           = ack_q[1];
    assign bus.p0_err           = err_q[0];
    assign bus.p1_err           = err_q[1];
    assign bus.p0_rdata         = rdata0_q;
    assign bus.p1_rdata         = rdata1_q;
    assign bus.ram_address      = addr_q;
    assign bus.ram_data_in      = wdata_q;
    assign bus.ram_write_enable = wen_q;
    assign bus.ram_read_request = rreq_q;
    assign bus.ram_read_ack     = rack_q;
    assign bus.busy             = busy_q;
    assign bus.grant            = grant_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: drivers push expected acks and RAM
// writes into queues, a monitor pops and compares them as the DUT produces them.
module tb_ram_port_arbiter;
  localparam int W = 14;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  ram_port_arbiter_if bus();

  ram_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [33:0]   exp_wr_q[$];
  logic [7:0]    exp_rd [2];
  int            rack_cnt = 0;
  int            exp_rack = 0;

  bit            model_en    = 1'b1;
  int            model_delay = 0;
  logic [7:0]    model_data  = 8'h00;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM wrapper model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ram_read_request && model_en) begin
        repeat (model_delay) @(negedge clk);
        bus.ram_data_out     = model_data;
        bus.ram_rd_data_pres = 1'b1;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.ram_read_ack) break;
        end
        bus.ram_rd_data_pres = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] got, e;
    logic [33:0]  wgot, we_exp;
    forever begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) begin
        got = {bus.busy, bus.grant, (bus.p1_ack ? bus.p1_err : bus.p0_err),
               (bus.p1_ack ? bus.p1_rdata : bus.p0_rdata), bus.p1_ack, bus.p0_ack};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack got=%h want=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL ack_check got=%h want=%h", got, e);
          end
        end
      end
      if (bus.ram_write_enable) begin
        wgot = {bus.ram_address, bus.ram_data_in};
        total++;
        if (exp_wr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got=%h want=none", wgot);
        end else begin
          we_exp = exp_wr_q.pop_front();
          if (wgot !== we_exp) begin
            bad++;
            $display("FAIL write_strobe got=%h want=%h", wgot, we_exp);
          end
        end
      end
      if (bus.ram_read_ack) rack_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_ack(input int port, input bit err, input logic [7:0] rdata);
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    exp_q.push_back({1'b1, oh, err, rdata, oh});
  endtask

  task automatic check_zero(input string name);
    logic [62:0] v;
    v = {bus.busy, bus.grant, bus.ram_write_enable, bus.ram_read_request, bus.ram_read_ack,
         bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.ram_address, bus.ram_data_in,
         bus.p0_rdata, bus.p1_rdata, dbg_state};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", name, v);
    end
  endtask

  task automatic wait_ack(input int port, input int lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (port == 1) ? bus.p1_ack : bus.p0_ack;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout port=%0d got=none want=ack", port);
    end else if (lat >= 0) begin
      total++;
      if (n != lat) begin
        bad++;
        $display("FAIL latency port=%0d got=%0d want=%0d", port, n, lat);
      end
    end
    if (port == 1) bus.p1_req = 1'b0;
    else           bus.p0_req = 1'b0;
  endtask

  task automatic raise(input int port, input bit we, input logic [25:0] addr, input logic [7:0] wd);
    if (port == 1) begin
      bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd; bus.p1_req = 1'b1;
    end else begin
      bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd; bus.p0_req = 1'b1;
    end
  endtask

  task automatic do_req(input int port, input bit we, input logic [25:0] addr,
                        input logic [7:0] wd, input int lat);
    raise(port, we, addr, wd);
    wait_ack(port, lat);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
    bus.p0_addr = '0; bus.p1_addr = '0; bus.p0_wdata = '0; bus.p1_wdata = '0;
    bus.ram_data_out = '0; bus.ram_rdy = 1'b1; bus.ram_rd_data_pres = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle_after_reset");

    // p0 write: strobe next cycle, ack the cycle after
    exp_wr_q.push_back({26'h0000010, 8'hA5});
    expect_ack(0, 1'b0, exp_rd[0]);
    do_req(0, 1'b1, 26'h0000010, 8'hA5, 2);

    // p1 read, RAM answers 3 cycles after the read request
    model_en = 1'b1; model_delay = 3; model_data = 8'h3C;
    exp_rd[1] = 8'h3C; exp_rack++;
    expect_ack(1, 1'b0, exp_rd[1]);
    do_req(1, 1'b0, 26'h0000011, 8'h00, 6);

    // both ports keep requesting: p0, p1, p0, p1
    exp_wr_q.push_back({26'h0000100, 8'h11});
    exp_wr_q.push_back({26'h0000200, 8'h22});
    exp_wr_q.push_back({26'h0000101, 8'h33});
    exp_wr_q.push_back({26'h0000201, 8'h44});
    expect_ack(0, 1'b0, exp_rd[0]);
    expect_ack(1, 1'b0, exp_rd[1]);
    expect_ack(0, 1'b0, exp_rd[0]);
    expect_ack(1, 1'b0, exp_rd[1]);
    fork
      begin
        do_req(0, 1'b1, 26'h0000100, 8'h11, -1);
        do_req(0, 1'b1, 26'h0000101, 8'h33, -1);
      end
      begin
        do_req(1, 1'b1, 26'h0000200, 8'h22, -1);
        do_req(1, 1'b1, 26'h0000201, 8'h44, -1);
      end
    join

    // p0 read with pres already high during the read command
    model_delay = 0; model_data = 8'h5A;
    exp_rd[0] = 8'h5A; exp_rack++;
    expect_ack(0, 1'b0, exp_rd[0]);
    do_req(0, 1'b0, 26'h3FFFFFF, 8'h00, 4);

    // p0 read never answered: err after 8 wait cycles, rdata kept
    model_en = 1'b0;
    expect_ack(0, 1'b1, exp_rd[0]);
    do_req(0, 1'b0, 26'h0000040, 8'h00, 10);
    model_en = 1'b1;

    // pres arrives in the last wait cycle: data wins over timeout
    model_delay = 8; model_data = 8'hC3;
    exp_rd[1] = 8'hC3; exp_rack++;
    expect_ack(1, 1'b0, exp_rd[1]);
    do_req(1, 1'b0, 26'h0000050, 8'h00, 11);

    // RAM not calibrated: request waits, granted on the edge after rdy rises
    bus.ram_rdy = 1'b0;
    raise(0, 1'b1, 26'h0000020, 8'h77);
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.grant} !== 3'b000) begin
      bad++;
      $display("FAIL not_ready_idle got=%b want=000", {bus.busy, bus.grant});
    end
    exp_wr_q.push_back({26'h0000020, 8'h77});
    expect_ack(0, 1'b0, exp_rd[0]);
    bus.ram_rdy = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.grant} !== 3'b101) begin
      bad++;
      $display("FAIL grant_after_rdy got=%b want=101", {bus.busy, bus.grant});
    end
    wait_ack(0, 1);
    @(negedge clk);

    // reset while waiting for read data: everything clears, no ack
    model_en = 1'b0;
    raise(1, 1'b0, 26'h1234567, 8'h00);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_in_rd_wait");
    bus.p1_req = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle_after_mid_reset");
    model_en = 1'b1;

    // normal service after reset
    model_delay = 2; model_data = 8'h96;
    exp_rd[0] = 8'h96; exp_rack++;
    expect_ack(0, 1'b0, exp_rd[0]);
    do_req(0, 1'b0, 26'h0000077, 8'h00, 5);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained got=%0d/%0d want=0/0", exp_q.size(), exp_wr_q.size());
    end
    total++;
    if (rack_cnt != exp_rack) begin
      bad++;
      $display("FAIL read_ack_count got=%0d want=%0d", rack_cnt, exp_rack);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end
endmodule
